// File: rtl/spi_master_ctrl_if.sv
// Host and serial-bus signal bundle for spi_master_ctrl.
// ABORT exists only when SPI_ABORT_EN is defined.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              START;
  logic              CKP;
  logic              CPH;
  logic [DATA_W-1:0] TX_DATA;
  logic              MISO;
  logic              SCK;
  logic              SS;
  logic              MOSI;
  logic [DATA_W-1:0] RX_DATA;
  logic              BUSY;
  logic              DONE;
`ifdef SPI_ABORT_EN
  logic              ABORT;
`endif

  // Handshake: START is a request level, taken only while idle and not in the
  // DONE cycle. BUSY stays high from acceptance through DONE. DONE is a
  // one-cycle pulse, and RX_DATA is valid from DONE until the next DONE.
  modport master (
    input  START, CKP, CPH, TX_DATA, MISO,
`ifdef SPI_ABORT_EN
    input  ABORT,
`endif
    output SCK, SS, MOSI, RX_DATA, BUSY, DONE
  );

  modport slave (
    output START, CKP, CPH, TX_DATA, MISO,
`ifdef SPI_ABORT_EN
    output ABORT,
`endif
    input  SCK, SS, MOSI, RX_DATA, BUSY, DONE
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master that sequences one full-duplex MSB-first frame per accepted START.
// Optional feature macro: SPI_ABORT_EN adds ABORT, which cancels a frame in progress.
module spi_master_ctrl #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  spi_master_ctrl_if.master bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   tx_next;
  logic                ckp_q;
  logic                cph_q;
  logic                div_tick;
  logic                sample_now;
  logic                last_edge;
  logic                abort_req;

  assign tx_next    = tx_shift << 1;
  assign div_tick   = (div_cnt == DIV_LAST);
  // Even edge count means the next edge is leading; CPH=0 samples there.
  assign sample_now = (cph_q == edge_cnt[0]);
  assign last_edge  = (edge_cnt == EDGE_LAST);
  assign state_dbg  = state;

`ifdef SPI_ABORT_EN
  assign abort_req = bus.ABORT && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      ckp_q       <= 1'b0;
      cph_q       <= 1'b0;
      bus.SS      <= 1'b1;
      bus.SCK     <= bus.CKP;
      bus.MOSI    <= 1'b0;
      bus.RX_DATA <= '0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
    end else if (abort_req) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      bus.SS   <= 1'b1;
      bus.SCK  <= ckp_q;
      bus.MOSI <= 1'b0;
      bus.BUSY <= 1'b0;
      bus.DONE <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        IDLE: begin
          bus.SCK  <= bus.CKP;
          bus.SS   <= 1'b1;
          bus.MOSI <= 1'b0;
          bus.BUSY <= 1'b0;
          // A START during the DONE cycle is dropped to guarantee an SS-high gap.
          if (bus.START && !bus.DONE) begin
            tx_shift <= bus.TX_DATA;
            rx_shift <= '0;
            ckp_q    <= bus.CKP;
            cph_q    <= bus.CPH;
            div_cnt  <= '0;
            edge_cnt <= '0;
            bus.SS   <= 1'b0;
            bus.BUSY <= 1'b1;
            bus.MOSI <= bus.CPH ? 1'b0 : bus.TX_DATA[DATA_W-1];
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_tick) begin
            div_cnt <= '0;
            state   <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        TRANSFER: begin
          if (div_tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (sample_now) begin
              rx_shift <= {rx_shift[DATA_W-2:0], bus.MISO};
            end else if (cph_q) begin
              bus.MOSI <= tx_shift[DATA_W-1];
              tx_shift <= tx_next;
            end else begin
              bus.MOSI <= tx_next[DATA_W-1];
              tx_shift <= tx_next;
            end
            if (last_edge) begin
              bus.SCK  <= ckp_q;
              edge_cnt <= '0;
              state    <= HOLD;
            end else begin
              bus.SCK <= ~bus.SCK;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_tick) begin
            div_cnt     <= '0;
            bus.SS      <= 1'b1;
            bus.SCK     <= ckp_q;
            bus.MOSI    <= 1'b0;
            bus.RX_DATA <= rx_shift;
            bus.DONE    <= 1'b1;
            state       <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl with a behavioural SPI slave.
// ABORT scenario is compiled only when SPI_ABORT_EN is defined.
module tb_spi_master_ctrl;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam int DONE_CYC = 1 + CLK_DIV * (2 * DATA_W + 2);

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] state_dbg;

  spi_master_ctrl_if #(.DATA_W(DATA_W)) bus ();

  spi_master_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int passed = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Behavioural slave: sampling edge taken from the mode table (posedge when CKP==CPH).
  logic              s_ckp = 1'b0;
  logic              s_cph = 1'b0;
  logic [DATA_W-1:0] slv_tx = '0;
  logic [DATA_W-1:0] slv_sh = '0;
  logic [DATA_W-1:0] slv_rx = '0;
  logic              slv_miso = 1'b0;
  logic              ss_prev = 1'b1;
  logic              sck_prev = 1'b0;

  assign bus.MISO = slv_miso;

  always @(bus.SCK or bus.SS) begin
    if (bus.SS === 1'b0 && ss_prev !== 1'b0) begin
      slv_sh = slv_tx;
      slv_rx = '0;
      if (!s_cph) slv_miso = slv_sh[DATA_W-1];
    end else if (bus.SS === 1'b0 && bus.SCK !== sck_prev) begin
      if ((bus.SCK === 1'b1) == (s_ckp == s_cph)) begin
        slv_rx = {slv_rx[DATA_W-2:0], bus.MOSI};
      end else if (s_cph) begin
        slv_miso = slv_sh[DATA_W-1];
        slv_sh   = slv_sh << 1;
      end else begin
        slv_sh   = slv_sh << 1;
        slv_miso = slv_sh[DATA_W-1];
      end
    end
    ss_prev  = bus.SS;
    sck_prev = bus.SCK;
  end

  // Driver tasks: called #1 after a posedge while the DUT is idle.
  task automatic start_frame(input logic [DATA_W-1:0] tx, input logic ckp,
                             input logic cph, input logic [DATA_W-1:0] reply);
    bus.CKP     = ckp;
    bus.CPH     = cph;
    s_ckp       = ckp;
    s_cph       = cph;
    slv_tx      = reply;
    bus.TX_DATA = tx;
    bus.START   = 1'b1;
    @(posedge CLK); #1;
    bus.START   = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.DONE !== 1'b1 && cyc < 300) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    bus.CKP = 1'b1;
    idle_cycles(2);
    checks++; if (bus.SCK !== 1'b1) $display("FAIL reset_sck_ckp1: got %b want 1", bus.SCK); else passed++;
    bus.CKP = 1'b0;
    idle_cycles(1);
    checks++; if (bus.SCK !== 1'b0) $display("FAIL reset_sck_ckp0: got %b want 0", bus.SCK); else passed++;
    checks++; if (bus.SS !== 1'b1) $display("FAIL reset_ss: got %b want 1", bus.SS); else passed++;
    checks++; if (bus.MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", bus.MOSI); else passed++;
    checks++; if (bus.RX_DATA !== 16'h0000) $display("FAIL reset_rx: got %h want 0000", bus.RX_DATA); else passed++;
    checks++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.BUSY); else passed++;
    checks++; if (bus.DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.DONE); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else passed++;
    RESET = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_mode0;
    int cyc;
    start_frame(16'hA5C3, 1'b0, 1'b0, 16'h0062);
    checks++; if (bus.SS !== 1'b0) $display("FAIL m0_ss_fall: got %b want 0", bus.SS); else passed++;
    checks++; if (bus.BUSY !== 1'b1) $display("FAIL m0_busy: got %b want 1", bus.BUSY); else passed++;
    checks++; if (bus.MOSI !== 1'b1) $display("FAIL m0_first_mosi: got %b want 1", bus.MOSI); else passed++;
    checks++; if (state_dbg !== 2'd1) $display("FAIL m0_setup_state: got %0d want 1", state_dbg); else passed++;
    wait_done(cyc);
    checks++; if (cyc !== DONE_CYC) $display("FAIL m0_done_cycle: got %0d want %0d", cyc, DONE_CYC); else passed++;
    checks++; if (bus.RX_DATA !== 16'h0062) $display("FAIL m0_rx: got %h want 0062", bus.RX_DATA); else passed++;
    checks++; if (slv_rx !== 16'hA5C3) $display("FAIL m0_mosi_word: got %h want a5c3", slv_rx); else passed++;
    checks++; if (bus.BUSY !== 1'b1 || bus.SS !== 1'b1 || bus.MOSI !== 1'b0)
      $display("FAIL m0_done_cycle_outputs: got busy=%b ss=%b mosi=%b want 1 1 0", bus.BUSY, bus.SS, bus.MOSI);
    else passed++;
    idle_cycles(1);
    checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0)
      $display("FAIL m0_after_done: got done=%b busy=%b want 0 0", bus.DONE, bus.BUSY);
    else passed++;
  endtask

  task automatic test_modes;
    int cyc;
    for (int m = 1; m <= 3; m++) begin
      logic ckp, cph;
      ckp = (m >= 2);
      cph = (m == 1 || m == 3);
      bus.CKP = ckp;
      idle_cycles(2);
      checks++; if (bus.SCK !== ckp) $display("FAIL mode%0d_idle_sck_pre: got %b want %b", m, bus.SCK, ckp); else passed++;
      start_frame(16'h8001, ckp, cph, 16'h0062);
      wait_done(cyc);
      checks++; if (bus.DONE !== 1'b1) $display("FAIL mode%0d_done_seen: got %b want 1", m, bus.DONE); else passed++;
      checks++; if (bus.RX_DATA !== 16'h0062) $display("FAIL mode%0d_rx: got %h want 0062", m, bus.RX_DATA); else passed++;
      checks++; if (slv_rx !== 16'h8001) $display("FAIL mode%0d_mosi_word: got %h want 8001", m, slv_rx); else passed++;
      checks++; if (bus.SCK !== ckp || bus.SS !== 1'b1)
        $display("FAIL mode%0d_idle_sck_post: got sck=%b ss=%b want %b 1", m, bus.SCK, bus.SS, ckp);
      else passed++;
      idle_cycles(1);
    end
  endtask

  task automatic test_start_ignored;
    int done_cnt = 0;
    int first_done = 0;
    idle_cycles(2);
    start_frame(16'h1234, 1'b0, 1'b0, 16'h5A5A);
    for (int c = 1; c <= 100; c++) begin
      if (bus.DONE === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (c == 5 || c == 20) begin
        bus.START   = 1'b1;
        bus.TX_DATA = 16'hFFFF;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge CLK); #1;
    end
    checks++; if (done_cnt !== 1) $display("FAIL ign_done_count: got %0d want 1", done_cnt); else passed++;
    checks++; if (first_done !== DONE_CYC) $display("FAIL ign_done_cycle: got %0d want %0d", first_done, DONE_CYC); else passed++;
    checks++; if (slv_rx !== 16'h1234) $display("FAIL ign_mosi_word: got %h want 1234", slv_rx); else passed++;
    checks++; if (bus.RX_DATA !== 16'h5A5A) $display("FAIL ign_rx: got %h want 5a5a", bus.RX_DATA); else passed++;
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int ss_high = 0;
    int busy_low = 0;
    logic [DATA_W-1:0] exp_rx;
    exp_q.push_back(16'hC001);
    exp_q.push_back(16'h0FF0);
    start_frame(16'h3C5A, 1'b0, 1'b0, 16'hC001);
    bus.START   = 1'b1;
    bus.TX_DATA = 16'h9669;
    slv_tx      = 16'h0FF0;
    for (int c = 1; c < 400 && ndone < 2; c++) begin
      if (bus.DONE === 1'b1) begin
        ndone++;
        exp_rx = exp_q.pop_front();
        checks++; if (bus.RX_DATA !== exp_rx) $display("FAIL b2b_rx%0d: got %h want %h", ndone, bus.RX_DATA, exp_rx); else passed++;
        checks++; if (slv_rx !== ((ndone == 1) ? 16'h3C5A : 16'h9669))
          $display("FAIL b2b_mosi%0d: got %h want %h", ndone, slv_rx, (ndone == 1) ? 16'h3C5A : 16'h9669);
        else passed++;
        if (ndone == 2) bus.START = 1'b0;
      end
      if (ndone == 1 && bus.SS === 1'b1) ss_high++;
      if (ndone == 1 && bus.BUSY === 1'b0) busy_low++;
      @(posedge CLK); #1;
    end
    checks++; if (ndone !== 2) $display("FAIL b2b_frames: got %0d want 2", ndone); else passed++;
    checks++; if (ss_high < 1) $display("FAIL b2b_ss_gap: got %0d want >=1", ss_high); else passed++;
    checks++; if (busy_low !== 1) $display("FAIL b2b_busy_gap: got %0d want 1", busy_low); else passed++;
    bus.START = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid;
    int cyc;
    int done_cnt = 0;
    bus.CKP = 1'b1;
    idle_cycles(2);
    start_frame(16'h1111, 1'b1, 1'b1, 16'h0F0F);
    idle_cycles(32);
    RESET = 1'b1;
    idle_cycles(1);
    checks++; if (bus.SS !== 1'b1) $display("FAIL rst_mid_ss: got %b want 1", bus.SS); else passed++;
    checks++; if (bus.SCK !== 1'b1) $display("FAIL rst_mid_sck: got %b want 1", bus.SCK); else passed++;
    checks++; if (bus.BUSY !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.BUSY); else passed++;
    checks++; if (bus.RX_DATA !== 16'h0000) $display("FAIL rst_mid_rx: got %h want 0000", bus.RX_DATA); else passed++;
    RESET = 1'b0;
    bus.CKP = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (bus.DONE === 1'b1) done_cnt++;
      @(posedge CLK); #1;
    end
    checks++; if (done_cnt !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", done_cnt); else passed++;
    start_frame(16'h00FF, 1'b0, 1'b0, 16'h3C3C);
    wait_done(cyc);
    checks++; if (cyc !== DONE_CYC) $display("FAIL rst_after_done_cycle: got %0d want %0d", cyc, DONE_CYC); else passed++;
    checks++; if (bus.RX_DATA !== 16'h3C3C) $display("FAIL rst_after_rx: got %h want 3c3c", bus.RX_DATA); else passed++;
    idle_cycles(2);
  endtask

`ifdef SPI_ABORT_EN
  task automatic test_abort;
    int cyc;
    int done_cnt = 0;
    start_frame(16'h4321, 1'b0, 1'b0, 16'h0062);
    wait_done(cyc);
    idle_cycles(2);
    start_frame(16'hBEEF, 1'b0, 1'b0, 16'hFFFF);
    idle_cycles(20);
    bus.ABORT = 1'b1;
    idle_cycles(1);
    bus.ABORT = 1'b0;
    checks++; if (bus.SS !== 1'b1) $display("FAIL abort_ss: got %b want 1", bus.SS); else passed++;
    checks++; if (bus.BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.BUSY); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL abort_state: got %0d want 0", state_dbg); else passed++;
    for (int c = 0; c < 80; c++) begin
      if (bus.DONE === 1'b1) done_cnt++;
      @(posedge CLK); #1;
    end
    checks++; if (done_cnt !== 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt); else passed++;
    checks++; if (bus.RX_DATA !== 16'h0062) $display("FAIL abort_rx_kept: got %h want 0062", bus.RX_DATA); else passed++;
  endtask
`endif

  initial begin
    RESET       = 1'b1;
    bus.START   = 1'b0;
    bus.CKP     = 1'b0;
    bus.CPH     = 1'b0;
    bus.TX_DATA = '0;
`ifdef SPI_ABORT_EN
    bus.ABORT   = 1'b0;
`endif
    @(posedge CLK); #1;
    test_reset();
    test_mode0();
    test_modes();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
